// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding, fault cause codes and PC step for the fetch sequencer
package ifetch_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, VALID = 2'd1, HALT = 2'd2} state_t;
  typedef enum logic [1:0] {CAUSE_NONE = 2'b00, CAUSE_TIMEOUT = 2'b01, CAUSE_MISALIGN = 2'b10} cause_t;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/ifetch_wait_cnt.sv
// ifetch_wait_cnt: counts imem wait cycles; term flags that the next wait reaches WAIT_MAX
module ifetch_wait_cnt #(
  parameter int WAIT_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);
  localparam logic [7:0] LAST = 8'(WAIT_MAX - 1);
  logic [7:0] cnt;
  assign term = cnt == LAST;
  // wait counter, cleared whenever the fetch is not stalled
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC owner and fetch sequencer with wait timeout and redirects (option: IFETCH_ALIGN_CHECK_EN)
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        imem_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inst_accept,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        fault,
  output logic [1:0]  fault_cause
);
  state_t      state, state_n;
  cause_t      cause, cause_n;
  logic [31:0] pc, pc_n;
  logic        cap, inc, clr, term, mis;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign mis = |redirect_pc[1:0];
`else
  assign mis = 1'b0;
`endif
  assign clr = ~inc;
  ifetch_wait_cnt #(.WAIT_MAX(WAIT_MAX)) u_wait (.clk, .rst, .clr, .inc, .term);
  assign imem_req    = state == FETCH;
  assign imem_addr   = pc;
  assign inst_valid  = state == VALID;
  assign fault       = state == HALT;
  assign fault_cause = cause;
  // next state: redirect beats response and accept; HALT is sticky until reset
  always_comb begin
    state_n = state;
    cause_n = cause;
    pc_n    = pc;
    cap     = 1'b0;
    inc     = 1'b0;
    if (state != HALT && redirect) begin
      state_n = mis ? HALT : FETCH;
      cause_n = mis ? CAUSE_MISALIGN : cause;
      pc_n    = mis ? pc : redirect_pc & ~32'h3;
    end else if (state == FETCH && imem_ready) begin
      cap     = 1'b1;
      state_n = VALID;
    end else if (state == FETCH) begin
      inc     = 1'b1;
      state_n = term ? HALT : FETCH;
      cause_n = term ? CAUSE_TIMEOUT : cause;
    end else if (state == VALID && inst_accept) begin
      state_n = FETCH;
      pc_n    = pc + PC_STEP;
    end
  end
  // state, PC and captured instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      cause    <= CAUSE_NONE;
      pc       <= RESET_PC;
      inst_out <= '0;
      pc_out   <= '0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      pc    <= pc_n;
      if (cap) begin
        inst_out <= imem_inst;
        pc_out   <= pc;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed and randomized checks of ifetch_ctrl against a behavioural model
module tb_ifetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam int WM = 8;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, imem_req, imem_ready, redirect, inst_accept, inst_valid, fault;
  logic [31:0] imem_addr, imem_inst, redirect_pc, inst_out, pc_out;
  logic [1:0] fault_cause;
  int vecs = 0, errs = 0, ncmp = 0;
  logic [31:0] m_pc, m_inst, m_pcout;
  logic m_valid, m_halt;
  logic [1:0] m_cause;
  int m_waits;

  ifetch_ctrl #(.RESET_PC(RST_PC), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .imem_ready(imem_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_accept(inst_accept), .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h0800_0005;
    if (a == 32'h14) return 32'h3401_4321;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign imem_inst = rom(imem_addr);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_inst = 0; m_pcout = 0; m_valid = 0; m_halt = 0; m_cause = 0; m_waits = 0;
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (m_halt) begin
    end else if (redirect) begin
      if (ALIGN && redirect_pc[1:0] != 2'b00) begin
        m_halt = 1; m_cause = 2'b10;
      end else begin
        m_pc = {redirect_pc[31:2], 2'b00}; m_valid = 0; m_waits = 0;
      end
    end else if (!m_valid) begin
      if (imem_ready) begin
        m_inst = rom(m_pc); m_pcout = m_pc; m_valid = 1;
      end else begin
        m_waits++;
        if (m_waits == WM) begin
          m_halt = 1; m_cause = 2'b01;
        end
      end
    end else if (inst_accept) begin
      m_pc = m_pc + 32'd4; m_valid = 0; m_waits = 0;
    end
  endtask

  task automatic compare();
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_halt && !m_valid});
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("inst_out", inst_out, m_inst);
    chk("pc_out", pc_out, m_pcout);
    chk("fault", {31'b0, fault}, {31'b0, m_halt});
    chk("fault_cause", {30'b0, fault_cause}, {30'b0, m_cause});
  endtask

  task automatic cyc(input logic r, input logic rd, input logic [31:0] rp, input logic rdy, input logic acc);
    rst = r; redirect = rd; redirect_pc = rp; imem_ready = rdy; inst_accept = acc;
    compare();
    model_step();
    @(posedge clk);
    #1;
    vecs++;
  endtask

  initial begin
    int thr;
    rst = 1; redirect = 0; redirect_pc = 0; imem_ready = 0; inst_accept = 0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {30'b0, fault_cause, fault}, 32'd0);
    cyc(0, 0, 0, 1, 1);
    chk("first_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_pc", pc_out, 32'h0);
    chk("first_inst", inst_out, 32'h0800_0005);
    cyc(0, 0, 0, 1, 1);
    chk("next_addr", imem_addr, 32'h4);
    cyc(0, 1, 32'h30, 1, 0);
    chk("redir_discard", {31'b0, inst_valid}, 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("valid_at_30", pc_out, 32'h30);
    cyc(0, 1, 32'h14, 0, 1);
    chk("redir_valid", {31'b0, inst_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h14);
    cyc(0, 0, 0, 1, 0);
    chk("redir_inst", inst_out, 32'h3401_4321);
    chk("redir_pc", pc_out, 32'h14);
    cyc(0, 1, 32'h8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_req", {31'b0, imem_req, inst_valid}, 32'd2);
    end
    cyc(0, 0, 0, 1, 0);
    chk("stall_done", {31'b0, inst_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("hold_pc", pc_out, 32'h8);
      chk("hold_inst", inst_out, rom(32'h8));
      chk("hold_req", {31'b0, imem_req}, 32'd0);
    end
    cyc(0, 0, 0, 1, 1);
    chk("accept_addr", imem_addr, 32'hC);
    cyc(0, 1, 32'hFFFF_FFFC, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("top_pc", pc_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 1);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(0, 1, 32'h16, 0, 0);
    if (ALIGN) chk("misalign", {30'b0, fault_cause, fault}, 32'b101);
    else chk("misalign_clr", imem_addr, 32'h14);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < WM - 1; i++) cyc(0, 0, 0, 0, 0);
    chk("pre_timeout", {31'b0, fault}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("timeout", {30'b0, fault_cause, fault}, 32'b011);
    cyc(0, 1, 32'h40, 1, 1);
    chk("halt_ignore", {30'b0, imem_req, inst_valid, fault}, 32'b001);
    chk("halt_pc", imem_addr, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_recover", {30'b0, imem_req, fault}, 32'b10);
    thr = 90;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      if (i % 200 == 0) thr = (i % 600 == 0) ? 90 : (i % 600 == 200) ? 40 : 5;
      rp = $urandom;
      if ($urandom_range(0, 1) == 0) rp[1:0] = 2'b00;
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, rp,
          $urandom_range(0, 99) < thr, $urandom_range(0, 99) < 60);
    end
    compare();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
